// File: rtl/dispatch_ctrl_pkg.sv
// Shared decode/dispatch types: decoded-lane payload, micro-op class and serialize FSM states.
package dispatch_ctrl_pkg;

  localparam int unsigned DISPQUE_ID_W = 2;
  localparam int unsigned PC_W         = 32;
  localparam int unsigned REG_ID_W     = 5;

  typedef enum logic [3:0] {
    MICOP_ALU   = 4'd0,
    MICOP_BRU   = 4'd1,
    MICOP_LDU   = 4'd2,
    MICOP_STU   = 4'd3,
    MICOP_MDU   = 4'd4,
    MICOP_CSR   = 4'd5,
    MICOP_FENCE = 4'd6,
    MICOP_NOP   = 4'd7
  } MicOp_t;

  typedef struct packed {
    logic [PC_W-1:0]         pc;
    MicOp_t                  mic_op;
    logic [DISPQUE_ID_W-1:0] dispQue_id;
    logic                    need_serialize;
    logic [REG_ID_W-1:0]     rd;
  } decInfo_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2
  } dispState_t;

endpackage

// File: rtl/disp_credit_cnt.sv
// Per-queue credit counter: free slots in one dispatch queue, refilled by dequeues, reset by squash.
module disp_credit_cnt
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned QUE_DEPTH = 16,
  parameter int unsigned NUM_W     = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             squash,
  input  logic [NUM_W-1:0]                 disp_num,
  input  logic [NUM_W-1:0]                 deq_num,
  output logic [$clog2(QUE_DEPTH+1)-1:0]   credit
);

  localparam int unsigned CREDIT_W = $clog2(QUE_DEPTH + 1);
  localparam int unsigned CALC_W   = CREDIT_W + 2;

  logic [CALC_W-1:0] credit_sum_c;

  // Extra headroom so an over-return or underflow is visible to the check below.
  always_comb begin
    credit_sum_c = CALC_W'(credit) - CALC_W'(disp_num) + CALC_W'(deq_num);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CREDIT_W'(QUE_DEPTH);
    end else if (squash) begin
      credit <= CREDIT_W'(QUE_DEPTH);
    end else begin
      credit <= CREDIT_W'(credit_sum_c);
    end
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    !squash |-> (credit_sum_c <= CALC_W'(QUE_DEPTH)));

endmodule

// File: rtl/dispatch_ctrl.sv
// Decode-to-dispatch steering: accepts the largest dispatchable in-order prefix, tracks queue
// credits and serializes flagged instructions. Optional stall counters under DISPATCH_PERF_EN.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned DECODE_WIDTH = 4,
  parameter int unsigned NUM_DISPQUE  = 3,
  parameter int unsigned QUE_DEPTH    = 16
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    i_squash,
  input  logic [DECODE_WIDTH-1:0]                                 i_dec_vld,
  input  decInfo_t [DECODE_WIDTH-1:0]                             i_dec_info,
  output logic [$clog2(DECODE_WIDTH+1)-1:0]                       o_dec_acpt_num,
  input  logic [NUM_DISPQUE-1:0][$clog2(DECODE_WIDTH+1)-1:0]      i_que_deq_num,
  input  logic                                                    i_rob_empty,
  input  logic                                                    i_serial_commit,
  output logic [DECODE_WIDTH-1:0]                                 o_disp_vld,
  output logic [DECODE_WIDTH-1:0][DISPQUE_ID_W-1:0]               o_disp_que,
  output decInfo_t [DECODE_WIDTH-1:0]                             o_disp_info
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]                                             o_perf_credit_stall,
  output logic [31:0]                                             o_perf_serial_stall
`endif
);

  localparam int unsigned ACPT_W   = $clog2(DECODE_WIDTH + 1);
  localparam int unsigned CREDIT_W = $clog2(QUE_DEPTH + 1);
  localparam int unsigned NUM_QID  = 1 << DISPQUE_ID_W;

  dispState_t                             state;
  logic [CREDIT_W-1:0]                    credit [NUM_DISPQUE];
  logic [NUM_QID-1:0][CREDIT_W-1:0]       credit_ext_c;
  logic [DECODE_WIDTH-1:0]                lane_fit_c;
  logic [DECODE_WIDTH-1:0]                idle_mask_c;
  logic [DECODE_WIDTH-1:0]                sel_mask_c;
  logic [ACPT_W-1:0]                      acpt_cnt_c;
  logic [NUM_DISPQUE-1:0][ACPT_W-1:0]     disp_num_c;
  logic                                   drain_issue_c;

  // Credits widened to the full id space; unpopulated ids read zero so their lanes never fit.
  always_comb begin
    credit_ext_c = '0;
    for (int q = 0; q < NUM_DISPQUE; q++) begin
      credit_ext_c[q] = credit[q];
    end
  end

  // A lane fits when lanes 0..k aimed at its queue do not exceed that queue's credit.
  always_comb begin
    lane_fit_c = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      int unsigned same_q;
      same_q = 0;
      for (int j = 0; j <= k; j++) begin
        if (i_dec_info[j].dispQue_id == i_dec_info[k].dispQue_id) begin
          same_q++;
        end
      end
      lane_fit_c[k] = (same_q <= 32'(credit_ext_c[i_dec_info[k].dispQue_id]));
    end
  end

  // Contiguous accepted prefix in IDLE; a serializing lane terminates it.
  always_comb begin
    logic run;
    run         = 1'b1;
    idle_mask_c = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      run            = run & i_dec_vld[k] & ~i_dec_info[k].need_serialize & lane_fit_c[k];
      idle_mask_c[k] = run;
    end
  end

  always_comb begin
    drain_issue_c = i_dec_vld[0] & i_rob_empty
                  & (credit_ext_c[i_dec_info[0].dispQue_id] != '0);
  end

  // Per-state acceptance; squash and reset force an empty prefix.
  always_comb begin
    sel_mask_c = '0;
    case (state)
      IDLE:    sel_mask_c = idle_mask_c;
      DRAIN:   sel_mask_c[0] = drain_issue_c;
      default: sel_mask_c = '0;
    endcase
    if (i_squash || !rst_n) begin
      sel_mask_c = '0;
    end
  end

  always_comb begin
    acpt_cnt_c = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      acpt_cnt_c = acpt_cnt_c + ACPT_W'(sel_mask_c[k]);
    end
  end

  assign o_dec_acpt_num = acpt_cnt_c;

  always_comb begin
    disp_num_c = '0;
    for (int q = 0; q < NUM_DISPQUE; q++) begin
      for (int k = 0; k < DECODE_WIDTH; k++) begin
        if (sel_mask_c[k] && (i_dec_info[k].dispQue_id == DISPQUE_ID_W'(q))) begin
          disp_num_c[q] = disp_num_c[q] + ACPT_W'(1);
        end
      end
    end
  end

  for (genvar q = 0; q < NUM_DISPQUE; q++) begin : g_credit
    disp_credit_cnt #(
      .QUE_DEPTH (QUE_DEPTH),
      .NUM_W     (ACPT_W)
    ) u_credit (
      .clk      (clk),
      .rst_n    (rst_n),
      .squash   (i_squash),
      .disp_num (disp_num_c[q]),
      .deq_num  (i_que_deq_num[q]),
      .credit   (credit[q])
    );
  end

  // Serialize FSM: park on a head serializer, issue it alone once the ROB is empty, then wait for commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (i_squash) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_dec_vld[0] && i_dec_info[0].need_serialize) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_issue_c) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (i_serial_commit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Enqueue-port registers; non-accepted lanes are zeroed so nothing stale is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_disp_vld  <= '0;
      o_disp_que  <= '0;
      o_disp_info <= '0;
    end else begin
      for (int k = 0; k < DECODE_WIDTH; k++) begin
        o_disp_vld[k]  <= sel_mask_c[k];
        o_disp_que[k]  <= sel_mask_c[k] ? i_dec_info[k].dispQue_id : '0;
        o_disp_info[k] <= sel_mask_c[k] ? i_dec_info[k] : '0;
      end
    end
  end

`ifdef DISPATCH_PERF_EN
  logic credit_stall_c;

  always_comb begin
    credit_stall_c = i_dec_vld[0] & (state == IDLE) & ~i_squash
                   & ~i_dec_info[0].need_serialize & (acpt_cnt_c == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_perf_credit_stall <= '0;
      o_perf_serial_stall <= '0;
    end else begin
      if (credit_stall_c) begin
        o_perf_credit_stall <= o_perf_credit_stall + 32'd1;
      end
      if (state == DRAIN || state == WAIT) begin
        o_perf_serial_stall <= o_perf_serial_stall + 32'd1;
      end
    end
  end
`endif

  for (genvar k = 0; k < DECODE_WIDTH; k++) begin : g_qid_chk
    a_qid_range: assert property (@(posedge clk) disable iff (!rst_n)
      i_dec_vld[k] |-> (32'(i_dec_info[k].dispQue_id) < NUM_DISPQUE));
  end

endmodule
